// File: rtl/dac_pkg.sv
// Shared definitions for the DAC signal chain.
//  - interp_state_t : control states of the linear interpolator
//  - step_width     : width of the per-beat increment (one guard bit over the
//                     sample width so a full-scale swing cannot wrap)
//  - acc_width      : width of the phase accumulator (sample width, plus the
//                     fractional bits of the upsampling ratio, plus the guard bit)
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    STARVE
  } interp_state_t;

  function automatic int step_width(input int width);
    return width + 1;
  endfunction

  function automatic int acc_width(input int width, input int osr_log2);
    return width + osr_log2 + 1;
  endfunction

endpackage

// File: rtl/axis_slot1.sv
// One-deep holding register for the next base-rate sample.
// The slot reports ready when it is empty, or when the consumer is draining
// it in this very cycle (pass-through), so a new sample can land in the same
// clock that the old one leaves.
// Ports:
//  aclk, arst    clock and asynchronous active-high reset
//  i_data        incoming sample
//  i_valid       incoming sample valid
//  i_capture_en  slot may capture (consumer is streaming)
//  i_pass        consumer drains the slot this cycle and frees it for a new sample
//  i_consume     consumer takes the held sample this cycle
//  o_ready       slot can accept a sample this cycle
//  o_data        held sample
//  o_valid       slot holds a sample
module axis_slot1
  import dac_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  input  logic             i_capture_en,
  input  logic             i_pass,
  input  logic             i_consume,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             w_load;

  assign o_ready = ~r_valid | i_pass;
  assign w_load  = i_valid & o_ready & i_capture_en;
  assign o_data  = r_data;
  assign o_valid = r_valid;

  // A load takes priority over a consume: when both happen together the old
  // sample is leaving and the new one replaces it, so the slot stays full.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_interp_lin.sv
// Linear-interpolating upsampler feeding the delta-sigma modulator.
// Every base-rate sample pair (x0, x1) becomes R = 2**OSR_LOG2 output beats
// that walk in a straight line from x0 towards x1. If the next sample is
// late the last sample is held, the stream keeps flowing, and a sticky
// underrun flag is raised.
// Ports:
//  aclk, arst            clock and asynchronous active-high reset
//  s_axis_data_*         base-rate signed sample stream (tdata/tvalid/tready)
//  m_axis_data_*         upsampled signed stream, tdata registered
//  phase                 index of the current beat within its segment
//  underrun              sticky flag, set when a segment ends with no next sample
//  clr_underrun          synchronous clear of underrun (a coincident set wins)
module axis_interp_lin
  import dac_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int OSR_LOG2 = 6
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [WIDTH-1:0]    s_axis_data_tdata,
  input  logic                s_axis_data_tvalid,
  output logic                s_axis_data_tready,
  output logic [WIDTH-1:0]    m_axis_data_tdata,
  output logic                m_axis_data_tvalid,
  input  logic                m_axis_data_tready,
  output logic [OSR_LOG2-1:0] phase,
  output logic                underrun,
  input  logic                clr_underrun
);

  localparam int STEP_W = step_width(WIDTH);
  localparam int ACC_W  = acc_width(WIDTH, OSR_LOG2);
  localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;

  interp_state_t       r_state;
  logic [WIDTH-1:0]    r_x1;
  logic [STEP_W-1:0]   r_step;
  logic [ACC_W-1:0]    r_acc;
  logic [OSR_LOG2-1:0] r_phase;
  logic                r_tvalid;
  logic                r_underrun;

  logic                w_fire;
  logic                w_seg_end;
  logic                w_in_fire;
  logic                w_capture_en;
  logic                w_consume;
  logic [WIDTH-1:0]    w_nxt;
  logic                w_nxt_v;
  logic [WIDTH-1:0]    w_new_sample;
  logic [STEP_W-1:0]   w_new_step;
  logic [ACC_W-1:0]    w_new_acc;
  logic [ACC_W-1:0]    w_acc_sum;

  // Handshake and segment-boundary decode. The slot only captures while
  // streaming; during IDLE/PRIME samples go straight into the datapath so
  // the first beat appears one clock after the second sample.
  assign w_fire       = r_tvalid & m_axis_data_tready;
  assign w_seg_end    = (r_state == RUN) & w_fire & (r_phase == PHASE_LAST);
  assign w_in_fire    = s_axis_data_tvalid & s_axis_data_tready;
  assign w_capture_en = (r_state == RUN) | (r_state == STARVE);
  assign w_consume    = w_nxt_v & (w_seg_end | (r_state == STARVE));

  // The accumulator holds x0 scaled by R, so no separate x0 register is
  // needed: starting a segment only needs the current x1 (the new x0) and
  // the incoming sample (the new x1). Two's-complement add/sub is
  // sign-agnostic, so plain vectors with explicit sign extension suffice.
  assign w_new_sample = (r_state == PRIME) ? s_axis_data_tdata : w_nxt;
  assign w_new_step   = {w_new_sample[WIDTH-1], w_new_sample} - {r_x1[WIDTH-1], r_x1};
  assign w_new_acc    = {r_x1[WIDTH-1], r_x1, {OSR_LOG2{1'b0}}};
  assign w_acc_sum    = r_acc + {{OSR_LOG2{r_step[STEP_W-1]}}, r_step};

  axis_slot1 #(
    .WIDTH(WIDTH)
  ) u_slot (
    .aclk         (aclk),
    .arst         (arst),
    .i_data       (s_axis_data_tdata),
    .i_valid      (s_axis_data_tvalid),
    .i_capture_en (w_capture_en),
    .i_pass       (w_seg_end),
    .i_consume    (w_consume),
    .o_ready      (s_axis_data_tready),
    .o_data       (w_nxt),
    .o_valid      (w_nxt_v)
  );

  // Selecting the integer bits of the accumulator is an arithmetic shift
  // with floor rounding; the result always lies between x0 and x1, so the
  // guard bit is never needed at the output.
  assign m_axis_data_tdata  = r_acc[OSR_LOG2 +: WIDTH];
  assign m_axis_data_tvalid = r_tvalid;
  assign phase              = r_phase;
  assign underrun           = r_underrun;

  // Control FSM and datapath registers. While stalled by the sink nothing
  // advances, which keeps tdata stable under backpressure. At the end of a
  // segment the accumulator is reloaded from x1 (identical to the running
  // sum there), which also makes STARVE output x1 without extra muxing.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state    <= IDLE;
      r_x1       <= '0;
      r_step     <= '0;
      r_acc      <= '0;
      r_phase    <= '0;
      r_tvalid   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (clr_underrun) begin
        r_underrun <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_x1    <= s_axis_data_tdata;
            r_state <= PRIME;
          end
        end
        PRIME: begin
          if (w_in_fire) begin
            r_x1     <= s_axis_data_tdata;
            r_acc    <= w_new_acc;
            r_step   <= w_new_step;
            r_phase  <= '0;
            r_tvalid <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (w_seg_end) begin
            r_phase <= '0;
            r_acc   <= w_new_acc;
            if (w_nxt_v) begin
              r_x1   <= w_nxt;
              r_step <= w_new_step;
            end else begin
              r_state    <= STARVE;
              r_underrun <= 1'b1;
            end
          end else if (w_fire) begin
            r_acc   <= w_acc_sum;
            r_phase <= r_phase + 1'b1;
          end
        end
        STARVE: begin
          if (w_nxt_v) begin
            r_x1    <= w_nxt;
            r_acc   <= w_new_acc;
            r_step  <= w_new_step;
            r_phase <= '0;
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_interp_lin.sv
// Self-checking bench for axis_interp_lin with WIDTH=16, OSR_LOG2=2 (R=4).
// A behavioural model tracks accepted samples, the current segment and the
// starve/underrun status, and is compared against the DUT on every cycle.
module tb_axis_interp_lin;

  localparam int WIDTH    = 16;
  localparam int OSR_LOG2 = 2;
  localparam int R        = 4;

  logic                       aclk = 1'b0;
  logic                       arst;
  logic signed [WIDTH-1:0]    sData;
  logic                       sValid;
  logic                       sReady;
  logic signed [WIDTH-1:0]    mData;
  logic                       mValid;
  logic                       mReady;
  logic [OSR_LOG2-1:0]        phase;
  logic                       underrun;
  logic                       clrUnderrun;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state: primed sample count, current segment endpoints and beat
  // index, pending samples waiting behind the segment, and flags.
  int  modelPrimed   = 0;
  bit  modelValid    = 0;
  bit  starving      = 0;
  bit  modelUnderrun = 0;
  int  segA = 0, segB = 0, segK = 0;
  int  pendQ[$];
  int  outLog[$];

  axis_interp_lin #(
    .WIDTH(WIDTH),
    .OSR_LOG2(OSR_LOG2)
  ) dut (
    .aclk               (aclk),
    .arst               (arst),
    .s_axis_data_tdata  (sData),
    .s_axis_data_tvalid (sValid),
    .s_axis_data_tready (sReady),
    .m_axis_data_tdata  (mData),
    .m_axis_data_tvalid (mValid),
    .m_axis_data_tready (mReady),
    .phase              (phase),
    .underrun           (underrun),
    .clr_underrun       (clrUnderrun)
  );

  // Free-running clock; inputs change at posedge+1, outputs are sampled on negedge.
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Ideal interpolated value: x0 + floor(k*(x1-x0)/R), plain integer arithmetic.
  function automatic int interpValue(input int a, input int b, input int k);
    int num, q;
    num = k * (b - a);
    q   = num / R;
    if ((num % R != 0) && (num < 0)) q = q - 1;
    return a + q;
  endfunction

  // Model update and comparison, once per cycle. The sample accepted in a
  // cycle joins the pending queue only after the segment-end decision, so a
  // sample arriving exactly at a segment end waits for the next one.
  always @(negedge aclk) begin : compareProc
    bit fire, segEnd, expReady, inFire, newUnder;
    int expData;
    if (arst) begin
      modelPrimed = 0; modelValid = 0; starving = 0; modelUnderrun = 0;
      segA = 0; segB = 0; segK = 0;
      pendQ.delete();
    end else begin
      fire     = modelValid && mReady;
      segEnd   = fire && !starving && (segK == R - 1);
      expReady = (pendQ.size() == 0) || segEnd;
      inFire   = sValid && expReady;
      checkOutput("m_tvalid", mValid, modelValid);
      checkOutput("underrun", underrun, modelUnderrun);
      checkOutput("s_tready", sReady, expReady);
      if (modelValid) begin
        expData = starving ? segB : interpValue(segA, segB, segK);
        checkOutput("m_tdata", mData, expData);
        checkOutput("phase", phase, starving ? 0 : segK);
      end
      if (mValid && mReady) outLog.push_back(int'(mData));
      newUnder = clrUnderrun ? 1'b0 : modelUnderrun;
      if (fire && !starving) begin
        if (segEnd) begin
          segK = 0;
          if (pendQ.size() > 0) begin
            segA = segB;
            segB = pendQ.pop_front();
          end else begin
            starving = 1;
            newUnder = 1;
          end
        end else begin
          segK++;
        end
      end else if (starving && pendQ.size() > 0) begin
        starving = 0;
        segA = segB;
        segB = pendQ.pop_front();
        segK = 0;
      end
      if (inFire) begin
        if (modelPrimed == 0) begin
          segB = int'(sData);
          modelPrimed = 1;
        end else if (modelPrimed == 1) begin
          segA = segB;
          segB = int'(sData);
          segK = 0;
          modelPrimed = 2;
          modelValid = 1;
        end else begin
          pendQ.push_back(int'(sData));
        end
      end
      modelUnderrun = newUnder;
    end
  end

  // Offer one sample and hold it until accepted; called at posedge+1 and
  // returns at posedge+1 just after the handshake edge.
  task automatic applyStimulus(input int data);
    int n = 0;
    sData  = WIDTH'(data);
    sValid = 1'b1;
    @(negedge aclk);
    while (!sReady && n < 200) begin
      n++;
      @(negedge aclk);
    end
    if (!sReady) timeoutFail("s_handshake");
    @(posedge aclk);
    #1;
    sValid = 1'b0;
  endtask

  task automatic doReset();
    @(posedge aclk);
    #1;
    arst = 1'b1; sValid = 1'b0; mReady = 1'b1; clrUnderrun = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    arst = 1'b0;
    outLog.delete();
  endtask

  task automatic waitPhase(input string name, input int target);
    int n = 0;
    @(negedge aclk);
    while (!(mValid && phase == target) && n < 100) begin
      n++;
      @(negedge aclk);
    end
    if (n >= 100) timeoutFail(name);
  endtask

  task automatic checkLog(input string name, input int expQ[$]);
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < outLog.size()) checkOutput($sformatf("%s[%0d]", name, i), outLog[i], expQ[i]);
      else timeoutFail($sformatf("%s[%0d]", name, i));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then a long randomized run against the model.
  initial begin : mainProc
    int e[$];
    int idx;
    bit acc;
    arst = 1'b1; sValid = 1'b0; sData = '0; mReady = 1'b1; clrUnderrun = 1'b0;

    // Pin the model's arithmetic with hand-computed values.
    checkOutput("model_ramp", interpValue(0, 400, 2), 200);
    checkOutput("model_neg", interpValue(100, -100, 3), -50);
    checkOutput("model_full", interpValue(32767, -32768, 3), -16385);
    checkOutput("model_floor", interpValue(3, -4, 1), 1);

    repeat (3) @(posedge aclk);
    #1;
    arst = 1'b0;
    @(negedge aclk);
    checkOutput("rst_tvalid", mValid, 0);
    checkOutput("rst_tdata", mData, 0);
    checkOutput("rst_phase", phase, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_tready", sReady, 1);
    @(posedge aclk);
    #1;
    outLog.delete();

    // Ramp
    applyStimulus(0); applyStimulus(400); applyStimulus(400); applyStimulus(400);
    repeat (12) @(posedge aclk);
    #1;
    e = '{0, 100, 200, 300, 400, 400, 400, 400};
    checkLog("ramp", e);

    // Negative slope
    doReset();
    applyStimulus(100); applyStimulus(-100); applyStimulus(-100);
    repeat (10) @(posedge aclk);
    #1;
    e = '{100, 50, 0, -50, -100};
    checkLog("negslope", e);

    // Full-scale swing
    doReset();
    applyStimulus(32767); applyStimulus(-32768);
    repeat (8) @(posedge aclk);
    #1;
    e = '{32767, 16383, -1, -16385};
    checkLog("fullscale", e);

    // Underrun, recovery and clear
    doReset();
    applyStimulus(0); applyStimulus(400);
    repeat (10) @(posedge aclk);
    #1;
    @(negedge aclk);
    checkOutput("starve_underrun", underrun, 1);
    checkOutput("starve_tvalid", mValid, 1);
    checkOutput("starve_tdata", mData, 400);
    @(posedge aclk);
    #1;
    applyStimulus(800);
    repeat (10) @(posedge aclk);
    #1;
    idx = -1;
    for (int i = 1; i + 2 < outLog.size(); i++) if (idx < 0 && outLog[i] == 500) idx = i;
    if (idx < 0) timeoutFail("recover_500");
    else begin
      checkOutput("recover_k0", outLog[idx-1], 400);
      checkOutput("recover_k2", outLog[idx+1], 600);
      checkOutput("recover_k3", outLog[idx+2], 700);
    end
    clrUnderrun = 1'b1;
    @(posedge aclk);
    #1;
    clrUnderrun = 1'b0;
    @(negedge aclk);
    checkOutput("clr_underrun", underrun, 0);

    // Backpressure at phase 2 of a ramp
    doReset();
    applyStimulus(0); applyStimulus(400); applyStimulus(400);
    sData = 16'sd400; sValid = 1'b1;
    waitPhase("bp_phase1", 1);
    @(posedge aclk);
    #1;
    mReady = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      checkOutput("bp_tdata", mData, 200);
      checkOutput("bp_phase", phase, 2);
      checkOutput("bp_s_tready", sReady, 0);
    end
    @(posedge aclk);
    #1;
    mReady = 1'b1;
    @(negedge aclk);
    checkOutput("bp_release_hold", mData, 200);
    @(negedge aclk);
    checkOutput("bp_resume", mData, 300);
    idx = 0;
    while (sValid && idx < 50) begin
      @(negedge aclk);
      acc = sReady;
      @(posedge aclk);
      #1;
      if (acc) sValid = 1'b0;
      idx++;
    end
    if (sValid) timeoutFail("bp_drain");
    sValid = 1'b0;

    // Reset in the middle of a segment, with underrun already set
    doReset();
    applyStimulus(0); applyStimulus(400);
    repeat (10) @(posedge aclk);
    #1;
    applyStimulus(800);
    waitPhase("rst_mid_phase1", 1);
    #2;
    arst = 1'b1;
    #1;
    checkOutput("rst_mid_tvalid", mValid, 0);
    checkOutput("rst_mid_underrun", underrun, 0);
    repeat (2) @(posedge aclk);
    #1;
    arst = 1'b0;
    @(negedge aclk);
    checkOutput("rst_mid_s_tready", sReady, 1);
    @(posedge aclk);
    #1;
    applyStimulus(10);
    @(negedge aclk);
    checkOutput("rst_mid_one_sample", mValid, 0);
    @(posedge aclk);
    #1;
    applyStimulus(20);
    @(negedge aclk);
    checkOutput("rst_mid_two_samples", mValid, 1);
    checkOutput("rst_mid_first", mData, 10);

    // Randomized traffic: alternate busy and sparse input blocks so both
    // full-slot backpressure and starvation occur, with random sink stalls.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      int prob;
      int v;
      @(negedge aclk);
      acc = sValid & sReady;
      @(posedge aclk);
      #1;
      prob = ((i / 500) % 2 == 1) ? 15 : 45;
      if (!sValid || acc) begin
        sValid = ($urandom_range(0, 99) < prob);
        if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 65535)) - 32768;
        else v = int'($urandom_range(0, 2000)) - 1000;
        sData = WIDTH'(v);
      end
      mReady      = ($urandom_range(0, 99) < 85);
      clrUnderrun = ($urandom_range(0, 99) < 3);
    end
    sValid = 1'b0; mReady = 1'b1; clrUnderrun = 1'b0;
    repeat (5) @(posedge aclk);
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
